uart_rx_datapath: RTL and testbench
===================================

Name: uart_rx_datapath

Overview:
- Serial receiver that consumes the line driven by the UART transmit datapath and recovers its frames.
- Frame format, LSB-first: 1 start bit (0), 8 data bits, 1 parity bit, 1 stop bit (1). This is the 9-bit payload the transmitter shifts out.
- Samples the line at OVERSAMPLE x baud, validates the start bit at mid-bit, checks parity and stop bit, then presents the byte with a one-cycle valid strobe to the downstream register/FIFO.

Parameters:
- OVERSAMPLE, 16: sample ticks per bit period; must be a power of 2, minimum 4.
- PARITY_ODD, 0: 0 = even parity expected over data[7:0] plus the parity bit; 1 = odd parity.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- rx_in  input  1  asynchronous serial line; idles high.
- tick  input  1  single-cycle enable at OVERSAMPLE x baud rate.
- data_out  output  8  last received data byte.
- data_valid  output  1  one-clk pulse when a frame completes.
- parity_err  output  1  parity status of the last frame.
- frame_err  output  1  stop-bit status of the last frame (1 = stop bit sampled low).
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (reset_n = 0 at a clk edge):
  - state = IDLE; data_out = 0; data_valid = 0; parity_err = 0; frame_err = 0; busy = 0.
  - Both synchronizer flops = 1; sample counter = 0; bit counter = 0.
  - Reset mid-frame abandons the frame silently; no data_valid is produced.
- Synchronizer: rx_in passes through a 2-flop synchronizer. All decisions use the synchronized value rx_s, which lags rx_in by 2 clk cycles.
- All state and counter updates happen only on clk edges where tick = 1, except data_valid, which is deasserted on the next clk regardless of tick.
- Sample counter: log2(OVERSAMPLE) bits, wraps naturally. Bit counter: 4 bits.
- IDLE:
  - On a tick with rx_s = 0: go to START, clear the sample counter.
  - Otherwise remain in IDLE.
- START:
  - Increment the sample counter each tick.
  - When the counter reaches OVERSAMPLE/2-1 (7 at default):
    - rx_s = 0: go to DATA, clear the sample counter and bit counter.
    - rx_s = 1: glitch; return to IDLE with no error flag.
- DATA:
  - Increment the sample counter each tick; at OVERSAMPLE-1 (mid-bit) sample rx_s.
  - Shift the sample into a 9-bit shift register from the MSB side (right shift), so the first received bit ends in bit 0.
  - Increment the bit counter. After the 9th sample (bit counter = 9), go to STOP and clear the sample counter.
- STOP: at sample count OVERSAMPLE-1, sample rx_s, then on the same edge:
  - data_out = shreg[7:0].
  - parity_err = (^shreg[8:0]) XOR PARITY_ODD; 0 means pass.
  - frame_err = ~rx_s.
  - data_valid = 1 for exactly one clk.
  - Next state: IDLE if rx_s = 1, else BREAK.
- BREAK: remain until a tick with rx_s = 1, then go to IDLE. No new start is detected while in BREAK, so a held-low line yields exactly one frame_err frame.
- Error flags and data_out hold their values until the next frame completes; they are not cleared by data_valid falling.
- busy = (state != IDLE). It is asserted from the edge entering START through the edge returning to IDLE.
- Latency: data_valid rises 2 clk + (OVERSAMPLE/2 + 10*OVERSAMPLE) ticks after the falling edge of rx_in. At default this is 2 clk + 168 ticks.
- tick held high continuously is legal: the block then runs 16 clk per bit.
- No overrun handling: a consumer missing the data_valid pulse loses the byte.

Test Plan:
- Reset with tick = 1 every clk. Send byte 0xA5 with parity 0 (even, popcount 4) and stop = 1 -> data_valid pulses once, data_out = 0xA5, parity_err = 0, frame_err = 0, busy = 0 afterwards.
- Send 0x01 with parity bit 0 (even check fails) -> data_out = 0x01, parity_err = 1. A following frame 0x03 with parity 0 -> parity_err returns to 0.
- Drive rx_in low for 5 ticks, then high -> START aborts at sample 7, returns to IDLE, no data_valid, error flags unchanged.
- Send 0x3C with stop bit 0, then hold the line low for 40 bit times, then release -> exactly one data_valid with frame_err = 1 and state BREAK; no further frames until the line goes high, after which 0x55 is received cleanly.
- Assert reset_n = 0 for 1 clk mid-way through data bit 4 of a frame -> all outputs return to 0, no data_valid. The next complete frame 0xFF with parity 0 is received correctly.
- Run with tick = 1 every 3rd clk and back-to-back frames 0x12, 0x34 (one stop bit each) -> two data_valid pulses, data_out 0x12 then 0x34, with 2 clk + 168 ticks latency measured per frame.

Source files
------------

// File: rtl/uart_rx_datapath_if.sv
// Bundles the serial line, oversample enable and received-frame outputs of the UART receiver.
// The slave modport is the receiver; the master modport drives the line and consumes frames.
interface uart_rx_datapath_if;
   logic       rx_in;
   logic       tick;
   logic [7:0] data_out;
   logic       data_valid;
   logic       parity_err;
   logic       frame_err;
   logic       busy;

   modport master (
      output rx_in,
      output tick,
      input  data_out,
      input  data_valid,
      input  parity_err,
      input  frame_err,
      input  busy
   );

   modport slave (
      input  rx_in,
      input  tick,
      output data_out,
      output data_valid,
      output parity_err,
      output frame_err,
      output busy
   );
endinterface

// File: rtl/uart_rx_datapath.sv
// Oversampling UART receiver: start validation at mid-bit, 8 data + parity + stop, LSB first.
// Presents each completed frame with a one-clk data_valid strobe and sticky status flags.
module uart_rx_datapath #(
   parameter int unsigned OVERSAMPLE = 16,
   parameter bit          PARITY_ODD = 1'b0
) (
   input logic               clk,
   input logic               reset_n,
   uart_rx_datapath_if.slave rx_if
);

   localparam int unsigned   CW       = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] MID_CNT  = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } state_t;

   // Nonzero result means the nine received bits fail the configured parity.
   function automatic logic parity_fail(input logic [8:0] bits, input logic odd);
      return (^bits) ^ odd;
   endfunction

   state_t        state_r, state_s;
   logic          rx_meta_r, rx_sync_r;
   logic [CW-1:0] sample_cnt_r, sample_cnt_s;
   logic [3:0]    bit_cnt_r, bit_cnt_s;
   logic [8:0]    shreg_r, shreg_s;
   logic [7:0]    data_r, data_s;
   logic          valid_r, valid_s;
   logic          perr_r, perr_s;
   logic          ferr_r, ferr_s;
   logic          busy_r;

   // Two-flop synchronizer plus all frame state; everything resets synchronously.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rx_meta_r    <= 1'b1;
         rx_sync_r    <= 1'b1;
         state_r      <= IDLE;
         sample_cnt_r <= '0;
         bit_cnt_r    <= 4'd0;
         shreg_r      <= 9'd0;
         data_r       <= 8'd0;
         valid_r      <= 1'b0;
         perr_r       <= 1'b0;
         ferr_r       <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         rx_meta_r    <= rx_if.rx_in;
         rx_sync_r    <= rx_meta_r;
         state_r      <= state_s;
         sample_cnt_r <= sample_cnt_s;
         bit_cnt_r    <= bit_cnt_s;
         shreg_r      <= shreg_s;
         data_r       <= data_s;
         valid_r      <= valid_s;
         perr_r       <= perr_s;
         ferr_r       <= ferr_s;
         busy_r       <= (state_s != IDLE);
      end
   end

   // Next-state and datapath updates; only tick edges advance the frame, valid self-clears.
   always_comb begin
      state_s      = state_r;
      sample_cnt_s = sample_cnt_r;
      bit_cnt_s    = bit_cnt_r;
      shreg_s      = shreg_r;
      data_s       = data_r;
      valid_s      = 1'b0;
      perr_s       = perr_r;
      ferr_s       = ferr_r;
      if (rx_if.tick) begin
         case (state_r)
            IDLE: begin
               if (!rx_sync_r) begin
                  state_s      = START;
                  sample_cnt_s = '0;
               end else begin
                  state_s = IDLE;
               end
            end
            START: begin
               if (sample_cnt_r == MID_CNT) begin
                  if (!rx_sync_r) begin
                     state_s      = DATA;
                     sample_cnt_s = '0;
                     bit_cnt_s    = 4'd0;
                  end else begin
                     state_s = IDLE;
                  end
               end else begin
                  sample_cnt_s = sample_cnt_r + 1'b1;
               end
            end
            DATA: begin
               sample_cnt_s = sample_cnt_r + 1'b1;
               if (sample_cnt_r == LAST_CNT) begin
                  shreg_s   = {rx_sync_r, shreg_r[8:1]};
                  bit_cnt_s = bit_cnt_r + 4'd1;
                  if (bit_cnt_r == 4'd8) begin
                     state_s      = STOP;
                     sample_cnt_s = '0;
                  end else begin
                     state_s = DATA;
                  end
               end else begin
                  state_s = DATA;
               end
            end
            STOP: begin
               sample_cnt_s = sample_cnt_r + 1'b1;
               if (sample_cnt_r == LAST_CNT) begin
                  data_s  = shreg_r[7:0];
                  perr_s  = parity_fail(shreg_r, PARITY_ODD);
                  ferr_s  = ~rx_sync_r;
                  valid_s = 1'b1;
                  state_s = rx_sync_r ? IDLE : BREAK;
               end else begin
                  state_s = STOP;
               end
            end
            BREAK: begin
               // A held-low line must go high before another start is accepted.
               if (rx_sync_r) begin
                  state_s = IDLE;
               end else begin
                  state_s = BREAK;
               end
            end
            default: begin
               state_s = IDLE;
            end
         endcase
      end else begin
         state_s = state_r;
      end
   end

   assign rx_if.data_out   = data_r;
   assign rx_if.data_valid = valid_r;
   assign rx_if.parity_err = perr_r;
   assign rx_if.frame_err  = ferr_r;
   assign rx_if.busy       = busy_r;

endmodule

// File: tb/tb_uart_rx_datapath.sv
// Directed bench for uart_rx_datapath: drives serial frames bit by bit against a tick-based timebase.
// Frame strobes are captured by a monitor; latency is measured in ticks from the synchronized start edge.
module tb_uart_rx_datapath;

   localparam int OS = 16;

   logic clk;
   logic reset_n;
   int   tick_div;
   int   tick_cnt;
   int   valid_cnt;
   int   valid_tick;
   int   lat_ref;
   int   n_pass;
   int   n_total;
   int   v0;

   uart_rx_datapath_if bus ();

   uart_rx_datapath #(.OVERSAMPLE(OS), .PARITY_ODD(1'b0)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .rx_if   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Tick generator: one clk in every tick_div is a tick edge.
   initial begin
      int div_cnt;
      div_cnt  = 0;
      bus.tick = 1'b1;
      forever begin
         @(negedge clk);
         div_cnt  = (div_cnt + 1 >= tick_div) ? 0 : div_cnt + 1;
         bus.tick = (div_cnt == 0);
      end
   end

   always @(posedge clk) begin
      if (bus.tick) tick_cnt <= tick_cnt + 1;
   end

   always @(negedge clk) begin
      if (bus.data_valid) begin
         valid_cnt  <= valid_cnt + 1;
         valid_tick <= tick_cnt;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic wait_ticks(input int n);
      int t0;
      t0 = tick_cnt;
      while (tick_cnt < t0 + n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      int t0;
      bus.rx_in = b;
      t0 = tick_cnt;
      while (tick_cnt < t0 + OS) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
      int t0;
      bus.rx_in = 1'b0;
      t0 = tick_cnt;
      @(negedge clk);
      @(negedge clk);
      lat_ref = tick_cnt;
      while (tick_cnt < t0 + OS) @(negedge clk);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(par);
      send_bit(stp);
   endtask

   initial begin
      logic [7:0] partial;
      n_pass    = 0;
      n_total   = 0;
      tick_cnt  = 0;
      valid_cnt = 0;
      valid_tick = 0;
      lat_ref   = 0;
      tick_div  = 1;
      bus.rx_in = 1'b1;
      reset_n   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_data",  bus.data_out,   8'h00);
      check("rst_valid", bus.data_valid, 1'b0);
      check("rst_perr",  bus.parity_err, 1'b0);
      check("rst_ferr",  bus.frame_err,  1'b0);
      check("rst_busy",  bus.busy,       1'b0);
      reset_n = 1'b1;
      wait_ticks(20);

      // Clean frame; valid lands 168 ticks after the detection tick.
      v0 = valid_cnt;
      send_frame(8'hA5, 1'b0, 1'b1);
      wait_ticks(2);
      check("a5_count", valid_cnt,            v0 + 1);
      check("a5_data",  bus.data_out,         8'hA5);
      check("a5_perr",  bus.parity_err,       1'b0);
      check("a5_ferr",  bus.frame_err,        1'b0);
      check("a5_busy",  bus.busy,             1'b0);
      check("a5_lat",   valid_tick - lat_ref, 169);

      send_frame(8'h01, 1'b0, 1'b1);
      wait_ticks(2);
      check("01_data", bus.data_out,   8'h01);
      check("01_perr", bus.parity_err, 1'b1);
      send_frame(8'h03, 1'b0, 1'b1);
      wait_ticks(2);
      check("03_data",  bus.data_out,   8'h03);
      check("03_perr",  bus.parity_err, 1'b0);
      check("03_count", valid_cnt,      v0 + 3);

      // Short low pulse: START aborts at mid-bit.
      v0 = valid_cnt;
      bus.rx_in = 1'b0;
      wait_ticks(5);
      check("glitch_busy_hi", bus.busy, 1'b1);
      bus.rx_in = 1'b1;
      wait_ticks(24);
      check("glitch_busy_lo", bus.busy,       1'b0);
      check("glitch_count",   valid_cnt,      v0);
      check("glitch_data",    bus.data_out,   8'h03);
      check("glitch_perr",    bus.parity_err, 1'b0);
      check("glitch_ferr",    bus.frame_err,  1'b0);

      // Stop bit low then line held low: one frame_err frame, BREAK until release.
      v0 = valid_cnt;
      send_frame(8'h3C, 1'b0, 1'b0);
      check("brk_count", valid_cnt,      v0 + 1);
      check("brk_data",  bus.data_out,   8'h3C);
      check("brk_ferr",  bus.frame_err,  1'b1);
      check("brk_perr",  bus.parity_err, 1'b0);
      check("brk_busy",  bus.busy,       1'b1);
      wait_ticks(OS * 39);
      check("brk_hold_count", valid_cnt, v0 + 1);
      check("brk_hold_busy",  bus.busy,  1'b1);
      bus.rx_in = 1'b1;
      wait_ticks(8);
      check("brk_release_busy", bus.busy, 1'b0);
      send_frame(8'h55, 1'b0, 1'b1);
      wait_ticks(2);
      check("55_count", valid_cnt,      v0 + 2);
      check("55_data",  bus.data_out,   8'h55);
      check("55_ferr",  bus.frame_err,  1'b0);
      check("55_perr",  bus.parity_err, 1'b0);

      // Reset during data bit 4 abandons the frame.
      v0 = valid_cnt;
      partial = 8'h5A;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(partial[i]);
      bus.rx_in = partial[4];
      wait_ticks(8);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      check("mrst_data",  bus.data_out,   8'h00);
      check("mrst_valid", bus.data_valid, 1'b0);
      check("mrst_perr",  bus.parity_err, 1'b0);
      check("mrst_ferr",  bus.frame_err,  1'b0);
      check("mrst_busy",  bus.busy,       1'b0);
      bus.rx_in = 1'b1;
      wait_ticks(OS * 6);
      check("mrst_count", valid_cnt, v0);
      send_frame(8'hFF, 1'b0, 1'b1);
      wait_ticks(2);
      check("ff_count", valid_cnt,      v0 + 1);
      check("ff_data",  bus.data_out,   8'hFF);
      check("ff_perr",  bus.parity_err, 1'b0);
      check("ff_ferr",  bus.frame_err,  1'b0);

      // Sparse ticks, back-to-back frames.
      tick_div = 3;
      wait_ticks(4);
      v0 = valid_cnt;
      send_frame(8'h12, 1'b0, 1'b1);
      check("12_count", valid_cnt,            v0 + 1);
      check("12_data",  bus.data_out,         8'h12);
      check("12_lat",   valid_tick - lat_ref, 169);
      send_frame(8'h34, 1'b1, 1'b1);
      wait_ticks(2);
      check("34_count", valid_cnt,            v0 + 2);
      check("34_data",  bus.data_out,         8'h34);
      check("34_perr",  bus.parity_err,       1'b0);
      check("34_lat",   valid_tick - lat_ref, 169);
      check("34_busy",  bus.busy,             1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
